tmds_channel_encoder: RTL and testbench

//  One TMDS lane encoder: 8b video pixel / 2b control -> 10b symbol. Sequences the
//  tm_choice transition-minimizing stage and adds DC-balance tracking with a running

---
 rtl/tmds_pkg.sv | 37 +++
 rtl/tmds_channel_encoder_tm_choice.sv | 30 +++
 rtl/tmds_channel_encoder.sv | 95 +++++++++
 tb/tb_tmds_channel_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants, state type and helpers for the TMDS lane encoder.
// Used by both the transition-minimizing stage and the DC-balance stage.
package tmds_pkg;

    localparam int unsigned TALLY_W = 5;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        CTRL  = 1'b0,
        VIDEO = 1'b1
    } enc_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_tm_choice.sv
// Transition-minimizing stage: 8b pixel -> 9b q_m, bit 8 = 1 for XOR chain, 0 for XNOR.
// Purely combinational; registered by the encoder's first pipeline stage.
module tm_choice
    import tmds_pkg::*;
(
    input  logic [7:0] data_in,
    output logic [8:0] q_m_out
);

    logic [3:0] n1;
    logic       use_xnor;
    logic [7:0] chain;

    always_comb begin
        n1       = popcount8(data_in);
        // XNOR wins on a majority of ones, or a tie with bit 0 clear.
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data_in[0]);
        chain    = '0;
        chain[0] = data_in[0];
        for (int unsigned i = 1; i < 8; i++) begin
            if (use_xnor) begin
                chain[i] = ~(chain[i-1] ^ data_in[i]);
            end else begin
                chain[i] = chain[i-1] ^ data_in[i];
            end
        end
        q_m_out = {~use_xnor, chain};
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: two-stage pipeline (tm_choice -> DC balance / control token select).
// Output symbol and running disparity are registered; reset is asynchronous.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [7:0]          data_in,
    input  logic [1:0]          control_in,
    input  logic                ve_in,
    output logic [9:0]          tmds_out,
    output logic [TALLY_W-1:0]  tally_out
);

    logic [8:0] qm_c;

    logic [8:0] qm_d,   qm_q;
    logic       ve_d,   ve_q;
    logic [1:0] ctrl_d, ctrl_q;

    enc_state_e                 state_d, state_q;
    logic [9:0]                 tmds_d,  tmds_q;
    logic signed [TALLY_W-1:0]  tally_d, tally_q;

    logic [3:0]                 n1;
    logic signed [TALLY_W-1:0]  disp;
    logic signed [TALLY_W-1:0]  tally_cur;

    tm_choice u_tm_choice (
        .data_in (data_in),
        .q_m_out (qm_c)
    );

    always_comb begin
        qm_d   = qm_c;
        ve_d   = ve_in;
        ctrl_d = control_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            qm_q   <= '0;
            ve_q   <= 1'b0;
            ctrl_q <= '0;
        end else begin
            qm_q   <= qm_d;
            ve_q   <= ve_d;
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        state_d   = ve_q ? VIDEO : CTRL;
        n1        = popcount8(qm_q[7:0]);
        // N1 - N0 = 2*N1 - 8, kept in tally width.
        disp      = $signed({n1, 1'b0}) - 5'sd8;
        // Entering video from control always starts from a zero tally.
        tally_cur = (state_q == VIDEO) ? tally_q : '0;
        tmds_d    = ctrl_token(ctrl_q);
        tally_d   = '0;

        if (state_d == VIDEO) begin
            if ((tally_cur == '0) || (n1 == 4'd4)) begin
                tmds_d  = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                tally_d = qm_q[8] ? (tally_cur + disp) : (tally_cur - disp);
            end else if ((!tally_cur[TALLY_W-1] && (n1 > 4'd4)) ||
                         ( tally_cur[TALLY_W-1] && (n1 < 4'd4))) begin
                tmds_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
                tally_d = tally_cur + (qm_q[8] ? 5'sd2 : 5'sd0) - disp;
            end else begin
                tmds_d  = {1'b0, qm_q[8], qm_q[7:0]};
                tally_d = tally_cur - (qm_q[8] ? 5'sd0 : 5'sd2) + disp;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= CTRL;
            tmds_q  <= '0;
            tally_q <= '0;
        end else begin
            state_q <= state_d;
            tmds_q  <= tmds_d;
            tally_q <= tally_d;
        end
    end

    assign tmds_out  = tmds_q;
    assign tally_out = tally_q;

    tally_in_range: assert property (@(posedge clk_in) disable iff (rst_in)
        (tally_q <= 5'sd10) && (tally_q >= -5'sd10));

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed vectors plus a random stream
// checked against a reference model and by decoding each video symbol back.
module tb_tmds_channel_encoder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] data_in;
    logic [1:0] control_in;
    logic       ve_in;
    logic [9:0] tmds_out;
    logic [4:0] tally_out;

    tmds_channel_encoder dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .data_in    (data_in),
        .control_in (control_in),
        .ve_in      (ve_in),
        .tmds_out   (tmds_out),
        .tally_out  (tally_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         due;
        logic [9:0] tmds;
        int         tally;
        logic [7:0] din;
        logic       vid;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   m_tally  = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int ones8(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic logic [8:0] ref_qm(input logic [7:0] d);
        logic [8:0] q;
        bit         xn;
        int         n;
        n  = ones8(d);
        xn = (n > 4) || (n == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        return q;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] v;
        logic [7:0] d;
        v    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return d;
    endfunction

    task automatic ref_model(input logic v, input logic [7:0] d, input logic [1:0] c,
                             input int t_in, output logic [9:0] o, output int t_out);
        logic [8:0] q;
        int         diff;
        int         q8;
        if (!v) begin
            case (c)
                2'b00:   o = 10'h354;
                2'b01:   o = 10'h0AB;
                2'b10:   o = 10'h154;
                default: o = 10'h2AB;
            endcase
            t_out = 0;
        end else begin
            q    = ref_qm(d);
            q8   = q[8] ? 1 : 0;
            diff = 2 * ones8(q[7:0]) - 8;
            if (t_in == 0 || diff == 0) begin
                o     = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                t_out = t_in + (q[8] ? diff : -diff);
            end else if ((t_in > 0 && diff > 0) || (t_in < 0 && diff < 0)) begin
                o     = {1'b1, q[8], ~q[7:0]};
                t_out = t_in + 2 * q8 - diff;
            end else begin
                o     = {1'b0, q[8], q[7:0]};
                t_out = t_in - 2 * (1 - q8) + diff;
            end
        end
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic [1:0] c,
                        input bit hand, input logic [9:0] h_tmds, input int h_tally);
        exp_t       e;
        logic [9:0] mo;
        int         mt;
        @(posedge clk_in);
        #1;
        ve_in      = v;
        data_in    = d;
        control_in = c;
        ref_model(v, d, c, m_tally, mo, mt);
        e.due = cyc + 2;
        e.vid = v;
        e.din = d;
        if (hand) begin
            e.tmds  = h_tmds;
            e.tally = h_tally;
        end else begin
            e.tmds  = mo;
            e.tally = mt;
        end
        m_tally = e.tally;
        sb.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [9:0] t_exp, input int y_exp);
        checks++;
        if (tmds_out !== t_exp) begin
            failures++;
            $display("FAIL %s tmds: got %h want %h", name, tmds_out, t_exp);
        end
        checks++;
        if ($signed(tally_out) != y_exp) begin
            failures++;
            $display("FAIL %s tally: got %0d want %0d", name, $signed(tally_out), y_exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL stale entry: due %0d now %0d", mon_e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                checks++;
                if (tmds_out !== mon_e.tmds) begin
                    failures++;
                    $display("FAIL tmds cyc %0d: got %h want %h", cyc, tmds_out, mon_e.tmds);
                end
                checks++;
                if ($signed(tally_out) != mon_e.tally) begin
                    failures++;
                    $display("FAIL tally cyc %0d: got %0d want %0d", cyc,
                             $signed(tally_out), mon_e.tally);
                end
                if (mon_e.vid) begin
                    checks++;
                    if (decode(tmds_out) !== mon_e.din) begin
                        failures++;
                        $display("FAIL decode cyc %0d: got %h want %h", cyc,
                                 decode(tmds_out), mon_e.din);
                    end
                    checks++;
                    if ($signed(tally_out) > 10 || $signed(tally_out) < -10) begin
                        failures++;
                        $display("FAIL range cyc %0d: got %0d want -10..10", cyc,
                                 $signed(tally_out));
                    end
                end
            end
        end
    end

    initial begin
        int   len;
        logic v;
        rst_in     = 1'b1;
        ve_in      = 1'b0;
        data_in    = '0;
        control_in = '0;
        #2;
        check_now("reset_state", 10'h000, 0);
        #20;
        rst_in = 1'b0;

        // control period, token 00
        repeat (4) send(1'b0, 8'h00, 2'b00, 1, 10'h354, 0);
        // two zero pixels back to back
        send(1'b1, 8'h00, 2'b00, 1, 10'h100, -8);
        send(1'b1, 8'h00, 2'b00, 1, 10'h3FF, 2);
        repeat (2) send(1'b0, 8'h00, 2'b00, 1, 10'h354, 0);
        // 0xFF from zero tally
        send(1'b1, 8'hFF, 2'b00, 1, 10'h200, -8);
        send(1'b0, 8'h00, 2'b01, 1, 10'h0AB, 0);
        // 0x10, 0x55 then control 11
        send(1'b1, 8'h10, 2'b00, 1, 10'h1F0, 0);
        send(1'b1, 8'h55, 2'b00, 1, 10'h133, 0);
        send(1'b0, 8'h00, 2'b11, 1, 10'h2AB, 0);
        send(1'b0, 8'h00, 2'b11, 1, 10'h2AB, 0);
        // single-cycle video pulse between control 10 symbols
        send(1'b0, 8'h00, 2'b10, 1, 10'h154, 0);
        send(1'b1, 8'hFF, 2'b10, 1, 10'h200, -8);
        send(1'b0, 8'h00, 2'b10, 1, 10'h154, 0);

        // asynchronous reset mid-video
        repeat (3) send(1'b1, 8'h00, 2'b00, 0, 10'h000, 0);
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check_now("async_reset", 10'h000, 0);
        sb.delete();
        m_tally = 0;
        ve_in   = 1'b0;
        @(posedge clk_in);
        #1;
        check_now("reset_hold", 10'h000, 0);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        send(1'b1, 8'h00, 2'b00, 1, 10'h100, -8);
        send(1'b1, 8'h00, 2'b00, 1, 10'h3FF, 2);

        // random video bursts
        v = 1'b1;
        for (int n = 0; n < 10000; n += len) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                send(v, 8'($urandom), 2'($urandom), 0, 10'h000, 0);
            end
            v = ~v;
        end

        repeat (4) @(posedge clk_in);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
